sram_req_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the fetch-side (inst) and memory-stage (data) requesters of the five-stage LoongArch32 pipeline. It performs the arbitration within the request cycle. It also tracks up to OT_DEPTH accepted but unanswered transactions in an in-order owner FIFO, and routes each data_ok/rdata back to the requester that issued it. Data requests have priority, and a streak counter prevents starvation of fetch.

---
 rtl/sram_req_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Shared SRAM-like port arbiter for the inst and data requesters.
// Data has priority, and a streak limit guarantees forward progress for fetch.
module sram_req_arbiter #(
    parameter int OT_DEPTH   = 4,
    parameter int MAX_STREAK = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        inst_req,
    input  logic                        inst_wr,
    input  logic [1:0]                  inst_size,
    input  logic [31:0]                 inst_addr,
    input  logic [3:0]                  inst_wstrb,
    input  logic [31:0]                 inst_wdata,
    output logic                        inst_addr_ok,
    output logic                        inst_data_ok,
    output logic [31:0]                 inst_rdata,
    input  logic                        data_req,
    input  logic                        data_wr,
    input  logic [1:0]                  data_size,
    input  logic [31:0]                 data_addr,
    input  logic [3:0]                  data_wstrb,
    input  logic [31:0]                 data_wdata,
    output logic                        data_addr_ok,
    output logic                        data_data_ok,
    output logic [31:0]                 data_rdata,
    output logic                        mem_req,
    output logic                        mem_wr,
    output logic [1:0]                  mem_size,
    output logic [31:0]                 mem_addr,
    output logic [3:0]                  mem_wstrb,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_addr_ok,
    input  logic                        mem_data_ok,
    input  logic [31:0]                 mem_rdata,
    output logic [$clog2(OT_DEPTH):0]   ot_count,
    output logic                        err_unexp
);

    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [OT_DEPTH-1:0] owner_q;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [SW-1:0]       streak;
    logic                lock_valid;
    logic                lock_owner;
    logic                err_q;

    logic full;
    logic force_inst;
    logic grant_data;
    logic accept;
    logic pop;
    logic head_data;

    always_comb begin
        full       = (count == CW'(OT_DEPTH));
        force_inst = (streak == SW'(MAX_STREAK)) && inst_req;
        // A stalled request keeps its owner so the memory side never sees it change.
        if (lock_valid)
            grant_data = lock_owner;
        else if (force_inst)
            grant_data = 1'b0;
        else
            grant_data = data_req;
        mem_req   = resetn & ~full & (inst_req | data_req);
        accept    = mem_req & mem_addr_ok;
        pop       = resetn & mem_data_ok & (count != '0);
        head_data = owner_q[rd_ptr];
    end

    always_comb begin
        mem_wr    = grant_data ? data_wr    : inst_wr;
        mem_size  = grant_data ? data_size  : inst_size;
        mem_addr  = grant_data ? data_addr  : inst_addr;
        mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
        mem_wdata = grant_data ? data_wdata : inst_wdata;
    end

    always_comb begin
        inst_addr_ok = accept & ~grant_data;
        data_addr_ok = accept & grant_data;
        inst_data_ok = pop & ~head_data;
        data_data_ok = pop & head_data;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        ot_count     = count;
        err_unexp    = err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                owner_q[wr_ptr] <= grant_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(accept) - CW'(pop);
            if (mem_data_ok && count == '0)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            streak     <= '0;
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
        end else begin
            if (accept) begin
                lock_valid <= 1'b0;
                if (grant_data && inst_req) begin
                    if (streak != SW'(MAX_STREAK))
                        streak <= streak + SW'(1);
                end else begin
                    streak <= '0;
                end
            end else if (mem_req) begin
                lock_valid <= 1'b1;
                lock_owner <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus a randomized run
// checked against a queue-based model of the arbitration rules.
module tb_sram_req_arbiter;

    localparam int OT = 4;
    localparam int MS = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  ot_count;
    logic        err_unexp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OT_DEPTH(OT), .MAX_STREAK(MS)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .ot_count(ot_count), .err_unexp(err_unexp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0;
        inst_wstrb = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0;
        data_wstrb = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        step();
        step();
        resetn = 1;
    endtask

    task automatic test_reset();
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        #2;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req);
        end
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
            errors++;
            $display("FAIL reset_oks: got %b want 0000",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        checks++;
        if (ot_count !== 3'd0 || err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d err=%b want 0/0", ot_count, err_unexp);
        end
        idle();
        step();
        resetn = 1;
    endtask

    task automatic test_single_read();
        inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
        #2;
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL single_addr_ok: got i=%b d=%b want 1/0", inst_addr_ok, data_addr_ok);
        end
        checks++;
        if (mem_addr !== 32'h1c00_0000 || ot_count !== 3'd0) begin
            errors++;
            $display("FAIL single_req: got addr=%h cnt=%0d want 1c000000/0", mem_addr, ot_count);
        end
        step();
        inst_req = 0; mem_addr_ok = 0;
        #2;
        checks++;
        if (ot_count !== 3'd1 || inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL single_wait: got cnt=%0d dok=%b want 1/0", ot_count, inst_data_ok);
        end
        step();
        mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        #2;
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_resp: got i=%b d=%b rdata=%h want 1/0/deadbeef",
                     inst_data_ok, data_data_ok, inst_rdata);
        end
        step();
        mem_data_ok = 0;
        checks++;
        if (ot_count !== 3'd0) begin
            errors++; $display("FAIL single_drain: got %0d want 0", ot_count);
        end
    endtask

    task automatic test_contention();
        bit exp_d [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        logic [31:0] exp_addr;
        inst_addr = 32'h1c00_0100; data_addr = 32'h0000_8000;
        for (int k = 0; k < 10; k++) begin
            inst_req = 1; data_req = 1; mem_addr_ok = 1;
            mem_data_ok = (k > 0); mem_rdata = 32'h100 + k;
            exp_addr = exp_d[k] ? data_addr : inst_addr;
            #2;
            checks++;
            if (data_addr_ok !== exp_d[k] || inst_addr_ok !== !exp_d[k]
                || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL contend_grant[%0d]: got d=%b i=%b addr=%h want d=%b addr=%h",
                         k, data_addr_ok, inst_addr_ok, mem_addr, exp_d[k], exp_addr);
            end
            if (k > 0) begin
                checks++;
                if (data_data_ok !== exp_d[k-1] || inst_data_ok !== !exp_d[k-1]) begin
                    errors++;
                    $display("FAIL contend_route[%0d]: got d=%b i=%b want d=%b",
                             k, data_data_ok, inst_data_ok, exp_d[k-1]);
                end
            end
            step();
        end
        idle();
        mem_data_ok = 1;
        #2;
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL contend_last: got i=%b d=%b want 1/0", inst_data_ok, data_data_ok);
        end
        step();
        mem_data_ok = 0;
        checks++;
        if (ot_count !== 3'd0) begin
            errors++; $display("FAIL contend_drain: got %0d want 0", ot_count);
        end
    endtask

    task automatic test_backpressure();
        data_req = 1; data_wr = 1; data_addr = 32'h0000_4444;
        data_wstrb = 4'hf; data_wdata = 32'h1234_5678; mem_addr_ok = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin inst_req = 1; inst_addr = 32'h1c00_0300; end
            if (k == 3) mem_addr_ok = 1;
            #2;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0000_4444 || mem_wr !== 1'b1
                || inst_addr_ok !== 1'b0 || data_addr_ok !== (k == 3)) begin
                errors++;
                $display("FAIL bp_lock[%0d]: got req=%b addr=%h wr=%b iok=%b dok=%b",
                         k, mem_req, mem_addr, mem_wr, inst_addr_ok, data_addr_ok);
            end
            step();
        end
        data_req = 0; data_wr = 0;
        #2;
        checks++;
        if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c00_0300) begin
            errors++;
            $display("FAIL bp_inst: got ok=%b addr=%h want 1/1c000300", inst_addr_ok, mem_addr);
        end
        step();
        idle();
        mem_data_ok = 1;
        #2;
        checks++;
        if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
            errors++; $display("FAIL bp_resp0: got d=%b i=%b want 1/0", data_data_ok, inst_data_ok);
        end
        step();
        #2;
        checks++;
        if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b1) begin
            errors++; $display("FAIL bp_resp1: got d=%b i=%b want 0/1", data_data_ok, inst_data_ok);
        end
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_full();
        inst_req = 1; inst_addr = 32'h1c00_0200; mem_addr_ok = 1;
        for (int k = 0; k < 6; k++) begin
            #2;
            checks++;
            if (inst_addr_ok !== (k < 4) || mem_req !== (k < 4)) begin
                errors++;
                $display("FAIL full_accept[%0d]: got ok=%b req=%b want %b",
                         k, inst_addr_ok, mem_req, k < 4);
            end
            step();
        end
        checks++;
        if (ot_count !== 3'd4) begin
            errors++; $display("FAIL full_count: got %0d want 4", ot_count);
        end
        mem_data_ok = 1;
        #2;
        checks++;
        if (mem_req !== 1'b0 || inst_data_ok !== 1'b1) begin
            errors++; $display("FAIL full_pop: got req=%b dok=%b want 0/1", mem_req, inst_data_ok);
        end
        step();
        mem_data_ok = 0;
        #2;
        checks++;
        if (ot_count !== 3'd3 || inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL full_reopen: got cnt=%0d ok=%b want 3/1", ot_count, inst_addr_ok);
        end
        step();
        mem_data_ok = 1;
        step();
        #2;
        checks++;
        if (inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop: got aok=%b dok=%b want 1/1", inst_addr_ok, inst_data_ok);
        end
        step();
        checks++;
        if (ot_count !== 3'd3) begin
            errors++; $display("FAIL full_pushpop_cnt: got %0d want 3", ot_count);
        end
        inst_req = 0; mem_addr_ok = 0;
        repeat (3) step();
        mem_data_ok = 0;
        checks++;
        if (ot_count !== 3'd0) begin
            errors++; $display("FAIL full_drain: got %0d want 0", ot_count);
        end
    endtask

    task automatic test_unexpected();
        checks++;
        if (err_unexp !== 1'b0) begin
            errors++; $display("FAIL unexp_pre: got %b want 0", err_unexp);
        end
        mem_data_ok = 1;
        #2;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL unexp_dok: got i=%b d=%b want 0/0", inst_data_ok, data_data_ok);
        end
        step();
        mem_data_ok = 0;
        repeat (3) step();
        checks++;
        if (err_unexp !== 1'b1 || ot_count !== 3'd0) begin
            errors++;
            $display("FAIL unexp_sticky: got err=%b cnt=%0d want 1/0", err_unexp, ot_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_req = 1; mem_addr_ok = 1;
        step();
        inst_req = 0; data_req = 1;
        step();
        mem_data_ok = 1;
        #2;
        checks++;
        if (ot_count !== 3'd2 || inst_data_ok !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre: got cnt=%0d dok=%b req=%b want 2/1/1",
                     ot_count, inst_data_ok, mem_req);
        end
        #1 resetn = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || ot_count !== 3'd0 || data_addr_ok !== 1'b0
            || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL arst_now: got req=%b cnt=%0d aok=%b i=%b d=%b",
                     mem_req, ot_count, data_addr_ok, inst_data_ok, data_data_ok);
        end
        idle();
        step();
        resetn = 1;
        mem_data_ok = 1;
        #2;
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL arst_stale: got i=%b d=%b want 0/0", inst_data_ok, data_data_ok);
        end
        step();
        mem_data_ok = 0;
        checks++;
        if (err_unexp !== 1'b1) begin
            errors++; $display("FAIL arst_err: got %b want 1", err_unexp);
        end
    endtask

    task automatic test_random();
        bit mq[$];
        int mstreak = 0;
        bit mlv = 0, mlo = 0, merr = 0;
        bit ip = 0, dp = 0;
        bit e_req, e_g, e_acc, e_resp, e_own;
        logic [70:0] e_fields;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1; inst_wr = $urandom_range(0, 3) == 0;
                inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom;
                inst_wstrb = 4'($urandom); inst_wdata = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; data_wr = $urandom_range(0, 1) == 0;
                data_size = 2'($urandom_range(0, 2)); data_addr = $urandom;
                data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            inst_req = ip; data_req = dp;
            mem_addr_ok = $urandom_range(0, 9) < 6;
            mem_data_ok = $urandom_range(0, 9) < 4;
            mem_rdata = $urandom;

            e_req  = (mq.size() < OT) && (ip || dp);
            e_g    = mlv ? mlo : ((mstreak == MS && ip) ? 1'b0 : dp);
            e_acc  = e_req && mem_addr_ok;
            e_resp = mem_data_ok && mq.size() > 0;
            e_own  = e_resp ? mq[0] : 1'b0;
            e_fields = e_g ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                           : {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
            #2;
            checks++;
            if (mem_req !== e_req || inst_addr_ok !== (e_acc && !e_g)
                || data_addr_ok !== (e_acc && e_g)) begin
                errors++;
                $display("FAIL rnd_grant@%0d: got req=%b i=%b d=%b want req=%b acc=%b g=%b",
                         cyc, mem_req, inst_addr_ok, data_addr_ok, e_req, e_acc, e_g);
            end
            if (e_req) begin
                checks++;
                if ({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} !== e_fields) begin
                    errors++;
                    $display("FAIL rnd_fields@%0d: got %h want %h", cyc,
                             {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, e_fields);
                end
            end
            checks++;
            if (inst_data_ok !== (e_resp && !e_own) || data_data_ok !== (e_resp && e_own)
                || inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
                errors++;
                $display("FAIL rnd_resp@%0d: got i=%b d=%b want resp=%b owner=%b",
                         cyc, inst_data_ok, data_data_ok, e_resp, e_own);
            end
            checks++;
            if (ot_count !== 3'(mq.size()) || err_unexp !== merr) begin
                errors++;
                $display("FAIL rnd_state@%0d: got cnt=%0d err=%b want %0d/%b",
                         cyc, ot_count, err_unexp, mq.size(), merr);
            end

            if (e_resp) void'(mq.pop_front());
            else if (mem_data_ok) merr = 1;
            if (e_acc) begin
                mq.push_back(e_g);
                if (e_g && ip) mstreak = (mstreak == MS) ? MS : mstreak + 1;
                else mstreak = 0;
                mlv = 0;
                if (e_g) dp = 0; else ip = 0;
            end else if (e_req) begin
                mlv = 1; mlo = e_g;
            end
            step();
        end
        idle();
    endtask

    initial begin
        resetn = 0;
        idle();
        step();
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_full();
        test_unexpected();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
